// File: rtl/stack_dp_pkg.sv
// rtl/stack_dp_pkg.sv - shared types for the dual-stack datapath
package stack_dp_pkg;

    // ALU operation codes, encoding matches the alu_op input
    typedef enum logic [2:0] {
        ALU_ADD  = 3'd0,
        ALU_SUB  = 3'd1,
        ALU_AND  = 3'd2,
        ALU_OR   = 3'd3,
        ALU_XOR  = 3'd4,
        ALU_NOT  = 3'd5,
        ALU_SHL  = 3'd6,
        ALU_PASS = 3'd7
    } alu_op_e;

    // Source select for the shared push mux
    typedef enum logic [1:0] {
        DSEL_IN    = 2'd0,
        DSEL_TOP   = 2'd1,
        DSEL_HOLD  = 2'd2,
        DSEL_STORE = 2'd3
    } dsel_e;

endpackage

// File: rtl/lifo_stack.sv
// rtl/lifo_stack.sv - single LIFO stack with occupancy flags and overflow/underflow pulses
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   push, pop        strobes; both together replace the top (or push when empty)
//   din              data written by a push
//   tos              top of stack, 0 when empty
//   ptr              occupancy 0..DEPTH
//   full, empty      occupancy flags
//   ovf, unf         combinational pulses for an ignored push / pop
module lifo_stack #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 32,
    parameter int PTR_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] tos,
    output logic [PTR_W-1:0] ptr,
    output logic             full,
    output logic             empty,
    output logic             ovf,
    output logic             unf
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_ptr;

    logic          w_full;
    logic          w_empty;
    logic          w_do_push;
    logic          w_do_pop;
    logic          w_replace;
    logic          w_first;
    logic          w_wr_en;
    logic [AW-1:0] w_top_addr;
    logic [AW-1:0] w_wr_addr;

    assign w_full     = (r_ptr == PTR_W'(DEPTH));
    assign w_empty    = (r_ptr == '0);
    assign w_do_push  = push & ~pop & ~w_full;
    assign w_do_pop   = pop & ~push & ~w_empty;
    // push+pop on a non-empty stack overwrites the top in place
    assign w_replace  = push & pop & ~w_empty;
    // push+pop on an empty stack degenerates to a plain push
    assign w_first    = push & pop & w_empty;
    assign w_wr_en    = w_do_push | w_replace | w_first;
    assign w_top_addr = AW'(r_ptr - PTR_W'(1));
    assign w_wr_addr  = w_replace ? w_top_addr : AW'(r_ptr);

    // Storage is deliberately not reset
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[w_wr_addr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (w_do_push || w_first) begin
            r_ptr <= r_ptr + PTR_W'(1);
        end else if (w_do_pop) begin
            r_ptr <= r_ptr - PTR_W'(1);
        end
    end

    assign tos   = w_empty ? '0 : r_mem[w_top_addr];
    assign ptr   = r_ptr;
    assign full  = w_full;
    assign empty = w_empty;
    assign ovf   = push & ~pop & w_full;
    assign unf   = pop & ~push & w_empty;

endmodule

// File: rtl/stack_data_path.sv
// rtl/stack_data_path.sv - dual-stack datapath with shared push mux, registered ALU and B-side comparator
//
// Optional feature macro: STACK_DP_SIGNED_EN (great becomes a two's-complement compare).
//
// Ports:
//   clk, rst                       clock, asynchronous active-low reset
//   data_in, d_select              push mux inputs (data_in / top / hold_b / store_b)
//   push_a, pop_a, push_b, pop_b   stack strobes
//   alu_go, alu_op                 start ALU op on current tops
//   load_hold, load_store          capture tos_b
//   err_clr                        clear sticky err
//   a_in                           mux output written by every push
//   top, carry, alu_valid          registered ALU result
//   ptr_*, full_*, empty_*         stack occupancy
//   great, equal                   hold_b < store_b, hold_b == store_b
//   err                            sticky overflow/underflow
module stack_data_path
    import stack_dp_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 32,
    localparam int PTR_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic [1:0]       d_select,
    input  logic             push_a,
    input  logic             pop_a,
    input  logic             push_b,
    input  logic             pop_b,
    input  logic             alu_go,
    input  logic [2:0]       alu_op,
    input  logic             load_hold,
    input  logic             load_store,
    input  logic             err_clr,
    output logic [WIDTH-1:0] a_in,
    output logic [WIDTH-1:0] top,
    output logic             carry,
    output logic             alu_valid,
    output logic [PTR_W-1:0] ptr_a,
    output logic [PTR_W-1:0] ptr_b,
    output logic             full_a,
    output logic             empty_a,
    output logic             full_b,
    output logic             empty_b,
    output logic             great,
    output logic             equal,
    output logic             err
);

    logic [WIDTH-1:0] w_tos_a;
    logic [WIDTH-1:0] w_tos_b;
    logic             w_ovf_a;
    logic             w_unf_a;
    logic             w_ovf_b;
    logic             w_unf_b;
    logic [WIDTH:0]   w_alu_res;

    logic [WIDTH-1:0] r_top;
    logic             r_carry;
    logic             r_alu_valid;
    logic [WIDTH-1:0] r_hold_b;
    logic [WIDTH-1:0] r_store_b;
    logic             r_err;

    always_comb begin
        a_in = data_in;
        case (dsel_e'(d_select))
            DSEL_IN:    a_in = data_in;
            DSEL_TOP:   a_in = r_top;
            DSEL_HOLD:  a_in = r_hold_b;
            DSEL_STORE: a_in = r_store_b;
            default:    a_in = data_in;
        endcase
    end

    lifo_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PTR_W(PTR_W)) u_stack_a (
        .clk(clk), .rst_n(rst), .push(push_a), .pop(pop_a), .din(a_in),
        .tos(w_tos_a), .ptr(ptr_a), .full(full_a), .empty(empty_a),
        .ovf(w_ovf_a), .unf(w_unf_a)
    );

    lifo_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PTR_W(PTR_W)) u_stack_b (
        .clk(clk), .rst_n(rst), .push(push_b), .pop(pop_b), .din(a_in),
        .tos(w_tos_b), .ptr(ptr_b), .full(full_b), .empty(empty_b),
        .ovf(w_ovf_b), .unf(w_unf_b)
    );

    // Bit WIDTH carries carry-out / borrow / shifted-out msb; zero for logic ops
    always_comb begin
        w_alu_res = '0;
        case (alu_op_e'(alu_op))
            ALU_ADD:  w_alu_res = {1'b0, w_tos_a} + {1'b0, w_tos_b};
            ALU_SUB:  w_alu_res = {1'b0, w_tos_a} - {1'b0, w_tos_b};
            ALU_AND:  w_alu_res = {1'b0, w_tos_a & w_tos_b};
            ALU_OR:   w_alu_res = {1'b0, w_tos_a | w_tos_b};
            ALU_XOR:  w_alu_res = {1'b0, w_tos_a ^ w_tos_b};
            ALU_NOT:  w_alu_res = {1'b0, ~w_tos_a};
            ALU_SHL:  w_alu_res = {w_tos_a, 1'b0};
            ALU_PASS: w_alu_res = {1'b0, w_tos_b};
            default:  w_alu_res = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_top       <= '0;
            r_carry     <= 1'b0;
            r_alu_valid <= 1'b0;
        end else begin
            r_alu_valid <= alu_go;
            if (alu_go) begin
                r_top   <= w_alu_res[WIDTH-1:0];
                r_carry <= w_alu_res[WIDTH];
            end
        end
    end

    // tos_b is the pre-pop value here, so a same-cycle pop does not disturb the capture
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hold_b  <= '0;
            r_store_b <= '0;
        end else begin
            if (load_hold) begin
                r_hold_b <= w_tos_b;
            end
            if (load_store) begin
                r_store_b <= w_tos_b;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err <= 1'b0;
        end else if (w_ovf_a || w_unf_a || w_ovf_b || w_unf_b) begin
            r_err <= 1'b1;
        end else if (err_clr) begin
            r_err <= 1'b0;
        end
    end

`ifdef STACK_DP_SIGNED_EN
    assign great = ($signed(r_hold_b) < $signed(r_store_b));
`else
    assign great = (r_hold_b < r_store_b);
`endif
    assign equal     = (r_hold_b == r_store_b);
    assign top       = r_top;
    assign carry     = r_carry;
    assign alu_valid = r_alu_valid;
    assign err       = r_err;

endmodule

// File: tb/tb_stack_data_path.sv
// tb/tb_stack_data_path.sv - directed self-checking bench for stack_data_path
module tb_stack_data_path;

    localparam int WIDTH = 16;
    localparam int DEPTH = 32;
    localparam int PTR_W = $clog2(DEPTH) + 1;
`ifdef STACK_DP_SIGNED_EN
    localparam logic EXP_GREAT = 1'b0;
`else
    localparam logic EXP_GREAT = 1'b1;
`endif

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] data_in;
    logic [1:0]       d_select;
    logic             push_a, pop_a, push_b, pop_b;
    logic             alu_go;
    logic [2:0]       alu_op;
    logic             load_hold, load_store, err_clr;
    logic [WIDTH-1:0] a_in, top;
    logic             carry, alu_valid;
    logic [PTR_W-1:0] ptr_a, ptr_b;
    logic             full_a, empty_a, full_b, empty_b;
    logic             great, equal, err;

    int n_pass = 0;
    int n_chk  = 0;

    stack_data_path #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .d_select(d_select),
        .push_a(push_a), .pop_a(pop_a), .push_b(push_b), .pop_b(pop_b),
        .alu_go(alu_go), .alu_op(alu_op), .load_hold(load_hold),
        .load_store(load_store), .err_clr(err_clr), .a_in(a_in), .top(top),
        .carry(carry), .alu_valid(alu_valid), .ptr_a(ptr_a), .ptr_b(ptr_b),
        .full_a(full_a), .empty_a(empty_a), .full_b(full_b), .empty_b(empty_b),
        .great(great), .equal(equal), .err(err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        push_a = 0; pop_a = 0; push_b = 0; pop_b = 0; alu_go = 0;
        load_hold = 0; load_store = 0; err_clr = 0;
    endtask

    initial begin
        rst = 0; data_in = '0; d_select = 2'd0; alu_op = 3'd0;
        idle();
        step(); step();
        check("rst_ptr_a", ptr_a, 0);
        check("rst_ptr_b", ptr_b, 0);
        check("rst_empty_a", empty_a, 1);
        check("rst_empty_b", empty_b, 1);
        check("rst_full_a", full_a, 0);
        check("rst_full_b", full_b, 0);
        check("rst_top", top, 0);
        check("rst_carry", carry, 0);
        check("rst_valid", alu_valid, 0);
        check("rst_err", err, 0);
        check("rst_great", great, 0);
        check("rst_equal", equal, 1);
        rst = 1;

        // push 5 then 3 onto A
        push_a = 1; data_in = 16'h0005; step();
        data_in = 16'h0003; step();
        idle();
        check("push2_ptr_a", ptr_a, 2);
        check("push2_empty_a", empty_a, 0);
        // tos_a seen through ADD with empty B (Y=0)
        alu_go = 1; alu_op = 3'd0; step(); idle();
        check("tos_a_add", top, 16'h0003);
        check("tos_a_valid", alu_valid, 1);
        step();
        check("valid_drop", alu_valid, 0);

        // A top 5, B top 7, SUB
        pop_a = 1; step(); idle();
        check("pop_ptr_a", ptr_a, 1);
        push_b = 1; data_in = 16'h0007; step(); idle();
        alu_go = 1; alu_op = 3'd1; step(); idle();
        check("sub_top", top, 16'hFFFE);
        check("sub_borrow", carry, 1);
        check("sub_valid", alu_valid, 1);
        step();
        check("sub_valid_once", alu_valid, 0);

        // fill B to DEPTH, then overflow
        for (int i = 1; i < DEPTH; i++) begin
            push_b = 1; data_in = 16'h0100 + 16'(i); step();
        end
        idle();
        check("fill_ptr_b", ptr_b, DEPTH);
        check("fill_full_b", full_b, 1);
        check("fill_err", err, 0);
        push_b = 1; data_in = 16'hDEAD; step(); idle();
        check("ovf_ptr_b", ptr_b, DEPTH);
        check("ovf_err", err, 1);
        alu_go = 1; alu_op = 3'd7; step(); idle();
        check("ovf_top_kept", top, 16'h011F);
        check("pass_carry", carry, 0);
        err_clr = 1; step(); idle();
        check("err_clr", err, 0);

        // drain B
        for (int i = 0; i < DEPTH; i++) begin
            pop_b = 1; step();
        end
        idle();
        check("drain_ptr_b", ptr_b, 0);
        check("drain_empty_b", empty_b, 1);
        check("drain_err", err, 0);

        // comparator: hold=2, store=0x8000
        push_b = 1; data_in = 16'h0002; step(); idle();
        load_hold = 1; step(); idle();
        push_b = 1; data_in = 16'h8000; step(); idle();
        load_store = 1; step(); idle();
        check("cmp_great", great, EXP_GREAT);
        check("cmp_equal", equal, 0);
        // capture happens before the same-cycle pop
        load_hold = 1; pop_b = 1; step(); idle();
        check("hold_prepop_equal", equal, 1);
        check("hold_prepop_great", great, 0);
        check("hold_prepop_ptr_b", ptr_b, 1);

        // underflow on A, set wins over clear
        pop_a = 1; step(); idle();
        check("pop_last_ptr_a", ptr_a, 0);
        check("pop_last_err", err, 0);
        pop_a = 1; err_clr = 1; step(); idle();
        check("unf_ptr_a", ptr_a, 0);
        check("unf_err_set_wins", err, 1);
        err_clr = 1; step(); idle();
        check("unf_err_clr", err, 0);
        push_a = 1; pop_a = 1; data_in = 16'h0009; step(); idle();
        check("pushpop_empty_ptr_a", ptr_a, 1);
        alu_go = 1; alu_op = 3'd0; step(); idle();
        check("add_9_2", top, 16'h000B);
        check("add_carry", carry, 0);

        // input mux
        d_select = 2'd1; #1;
        check("mux_top", a_in, 16'h000B);
        d_select = 2'd2; #1;
        check("mux_hold", a_in, 16'h8000);
        d_select = 2'd0; data_in = 16'h1234; #1;
        check("mux_in", a_in, 16'h1234);

        // SHL with msb set: push 0x8001 on A
        push_a = 1; data_in = 16'h8001; step(); idle();
        alu_go = 1; alu_op = 3'd6; step(); idle();
        check("shl_top", top, 16'h0002);
        check("shl_carry", carry, 1);

        // reset mid-operation with ptr_a=3 and alu_go high
        push_a = 1; data_in = 16'h0011; step(); idle();
        check("pre_rst_ptr_a", ptr_a, 3);
        alu_go = 1; alu_op = 3'd0; err_clr = 0;
        #2 rst = 0; #1;
        check("mid_rst_ptr_a", ptr_a, 0);
        check("mid_rst_empty_a", empty_a, 1);
        check("mid_rst_ptr_b", ptr_b, 0);
        check("mid_rst_top", top, 0);
        check("mid_rst_carry", carry, 0);
        check("mid_rst_equal", equal, 1);
        alu_go = 0;
        step();
        check("mid_rst_valid", alu_valid, 0);
        rst = 1;
        step();
        check("post_rst_valid", alu_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/stack_data_path.md
# stack_data_path

Parametrised dual-stack datapath: two LIFO stacks (A and B) share one input mux and feed a registered ALU, with two holding registers and a comparator on B-side values. It is the next generation of the 16-bit/32-entry stack datapath. New over that block: configurable width and depth, per-stack full/empty, a sticky overflow/underflow error, a registered multi-op ALU with carry and valid pulse, and independent hold/store loads. It sits under the stack-machine controller, which drives all strobes.

## Interface
- WIDTH, 16, data width (≥2)
- DEPTH, 32, entries per stack (power of two, ≥2); localparam PTR_W = $clog2(DEPTH)+1
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- data_in  in  WIDTH  external operand
- d_select  in  2  a_in source: 0 data_in, 1 top, 2 hold_b, 3 store_b
- push_a, pop_a, push_b, pop_b  in  1  stack strobes
- alu_go  in  1  start ALU op on current tops
- alu_op  in  3  ALU operation code
- load_hold, load_store  in  1  capture tos_b into hold_b / store_b
- err_clr  in  1  clear sticky err
- a_in  out  WIDTH  mux output, written by every push (combinational)
- top  out  WIDTH  registered ALU result
- carry  out  1  registered carry/borrow
- alu_valid  out  1  one-cycle pulse when top updates
- ptr_a, ptr_b  out  PTR_W  occupancy (0..DEPTH)
- full_a, empty_a, full_b, empty_b  out  1  occupancy flags
- great  out  1  hold_b < store_b
- equal  out  1  hold_b == store_b
- err  out  1  sticky overflow/underflow

## Operation
- Stack: push writes a_in to mem[ptr], ptr+1; pop ptr-1; tos = mem[ptr-1], forced 0 when empty.
- Push and pop same cycle: non-empty -> replace top (mem[ptr-1]=a_in, ptr unchanged); empty -> plain push.
- Push alone when full: ignored, err set. Pop alone when empty: ignored, err set. Both stacks independent.
- ALU operands X=tos_a, Y=tos_b; results truncated to WIDTH: 0 ADD (carry=carry-out), 1 SUB X-Y (carry=borrow), 2 AND, 3 OR, 4 XOR, 5 NOT X, 6 SHL X by 1 (carry=X msb), 7 PASS Y. Logic ops clear carry.
- load_hold and load_store are independent; both may fire in one cycle. They capture tos_b before any same-cycle pop.
- great/equal are combinational from hold_b/store_b; compare is unsigned unless configured otherwise.
- err: set on any overflow/underflow; err_clr clears; set wins over clear in the same cycle.

## Timing
- Reset values: ptr_a=ptr_b=0, empty_*=1, full_*=0, top=0, carry=0, alu_valid=0, hold_b=store_b=0, err=0, great=0, equal=1. Memory contents are not reset.
- Reset asserted mid-operation: all of the above is restored immediately, and in-flight alu_go is dropped.
- Pointer, flags, and tos update after the strobe edge: one-cycle latency.
- ALU: alu_go sampled at edge N uses the tops before any same-edge push/pop. top and carry are valid, and alu_valid is high, for cycle N+1. Back-to-back alu_go gives one result per cycle.
- a_in is combinational; d_select=1 while pushing writes the current top (no bypass of a same-cycle ALU result).

## Configuration
- STACK_DP_SIGNED_EN defined: great compares hold_b and store_b as two's complement; SUB carry stays an unsigned borrow.
- STACK_DP_SIGNED_EN undefined: great is an unsigned compare.

## Structure
- Package stack_dp_pkg:
  - alu_op_e enum (ADD..PASS)
  - dsel_e enum (DSEL_IN, DSEL_TOP, DSEL_HOLD, DSEL_STORE)
- Sub-module lifo_stack, parametrised by WIDTH and DEPTH. Ports: push, pop, din, tos, ptr, full, empty, ovf, unf. Instantiated twice.
- ALU, mux, and registers stay in the top module.

## Test plan
- Reset, d_select=0, push_a with data_in=0x0005 then 0x0003 -> ptr_a=2, tos_a=0x0003, empty_a=0.
- A tops 0x0005, B top 0x0007, alu_op=SUB, alu_go -> next cycle top=0xFFFE, carry=1, alu_valid=1 for exactly one cycle.
- Push DEPTH values to B, then push once more -> ptr_b=DEPTH, full_b=1, err=1, top entry unchanged. err_clr -> err=0.
- Pop A when empty -> ptr_a stays 0, err=1. Push and pop A together when empty -> ptr_a=1.
- B top 0x0002, load_hold; push 0x8000, load_store -> great=1 unsigned, great=0 with STACK_DP_SIGNED_EN. Also check equal=0.
- Assert rst mid-sequence with ptr_a=3 and alu_go high -> all outputs at reset values on the same cycle, no alu_valid afterwards.
